mult_div_unit: RTL
==================

# mult_div_unit

Multi-cycle multiply/divide unit with HI/LO registers in the E stage of the 5-stage MIPS pipeline. It feeds the stall controller: it raises `md_stall` whenever the instruction in D needs HI/LO or the MD unit while an MD operation is starting or in flight. The pipeline's `Stall_Data` is the OR of `md_stall` and the register-hazard stall. It also honours the exception/interrupt cancel from M, so a cancelled E-stage instruction never alters HI/LO.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

Ports:
- `clk`  in  1  pipeline clock; everything is sampled on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  E-stage instruction is MULT/MULTU/DIV/DIVU.
- `md_op`  in  3  operation code (see package).
- `md_we`  in  1  E-stage instruction is MTHI/MTLO.
- `cancel`  in  1  exception or interrupt being taken this cycle; the E-stage instruction is void.
- `a`  in  32  rs operand.
- `b`  in  32  rt operand.
- `d_md_use`  in  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- `hi`  out  32  HI register (MFHI source).
- `lo`  out  32  LO register (MFLO source).
- `busy`  out  1  operation in flight.
- `md_stall`  out  1  `d_md_use & (start_eff | busy)`, combinational.

## Operation
- `start_eff = start & ~cancel & ~busy`. `wr_eff = md_we & ~cancel & ~busy`.
- Idle plus `start_eff`:
  - latch `md_op`, `a`, `b`;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - assert `busy`.
- MULT: signed 32x32 product; HI = bits [63:32], LO = bits [31:0]. MULTU: the same, unsigned.
- DIV: LO = signed quotient, HI = signed remainder, truncating toward zero; the remainder takes the sign of the dividend. DIVU: the same, unsigned.
- Divide by zero (`b == 0`): the operation still occupies DIV_CYCLES, but HI/LO stay unchanged.
- Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0.
- MTHI/MTLO: `wr_eff` writes `a` into HI or LO at the edge and does not set `busy`.
- The result is computed from the latched operands. Changes on `a`/`b` after the start edge have no effect.
- `start` or `md_we` while `busy`: ignored. This cannot occur under correct stalling; the bench checks it anyway.
- `cancel` during `busy`: no effect. The in-flight operation belongs to a committed instruction and completes normally.
- State machine:
  - IDLE: go to BUSY on `start_eff`.
  - BUSY: decrement the counter each edge. At the edge where the counter goes 1→0, write HI/LO and return to IDLE.
- `hi`/`lo` are register outputs. There is no bypass of an in-flight result; the stall guarantees MFHI/MFLO never read early.

## Timing
- Reset values: `hi = 0`, `lo = 0`, `busy = 0`, counter 0, state IDLE.
- `md_stall` is 0 immediately after reset because `busy = 0`; it can be high in that cycle only if `start` and `d_md_use` are both high.
- Reset mid-operation aborts the operation. HI/LO are cleared and the result is never written.
- Latency, with `start_eff` sampled at edge 0:
  - `busy` is high in cycles 1..N (N = MULT_CYCLES or DIV_CYCLES);
  - HI/LO are updated at edge N;
  - `busy` is low from cycle N+1;
  - an MFHI in D is released in cycle N+1.
- `md_stall` is combinational. In the start cycle itself it is high if `d_md_use`, because `start_eff` is included.
- MTHI/MTLO: the new value is visible on `hi`/`lo` the cycle after the write edge.
- `reset` has priority over everything; `cancel` has priority over `start`/`md_we`.

## Structure
- Shared package `md_pkg`:
  - `md_op` encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - Default cycle-count constants.
- The decoder, which produces `start`/`md_we`/`d_md_use`, imports the same package.
- No sub-module is required. The arithmetic is one combinational function on the latched operands, registered at completion.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3 → after 5 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=-7, b=2 → `busy` high exactly 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=7, b=2 → LO=3, HI=1.
- DIV with b=0 after MTHI 0x1234 and MTLO 0x5678 → `busy` high 10 cycles, HI=0x1234 and LO=0x5678 unchanged.
- MULT start with `d_md_use`=1 (MFLO in D) → `md_stall`=1 in the start cycle and cycles 1..5, 0 in cycle 6; LO is correct in cycle 6.
- `start` with `cancel`=1 → `busy` stays 0 and HI/LO are unchanged. `cancel` pulsed in cycle 3 of a DIV → the result is still written at edge 10.
- `reset` asserted in cycle 3 of a MULT → next cycle `busy`=0, HI=LO=0, and no late write follows.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder that drives it:
// operation encodings, default latencies and the HI/LO result function.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int CNT_W           = 8;

  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  // wr is cleared for a zero divisor so HI/LO keep their previous contents.
  function automatic md_result_t md_compute(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    md_result_t       res;
    logic signed [63:0] sp;
    logic [63:0]      up;
    res = '0;
    res.wr = 1'b1;
    sp = '0;
    up = '0;
    case (op)
      OP_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        res.hi = sp[63:32];
        res.lo = sp[31:0];
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        res.hi = up[63:32];
        res.lo = up[31:0];
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          res.wr = 1'b0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res.lo = 32'h8000_0000;
          res.hi = 32'd0;
        end else begin
          res.lo = $signed(a) / $signed(b);
          res.hi = $signed(a) % $signed(b);
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          res.wr = 1'b0;
        end else begin
          res.lo = a / b;
          res.hi = a % b;
        end
      end
      default: res.wr = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with HI/LO registers. Operands are latched at
// start, the result is written when the busy counter expires; md_stall holds D.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        md_we,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic             in_busy;
  logic             start_eff, wr_eff, done;
  md_result_t       res;

  // Handshake: start/md_we are accepted only while idle and not cancelled;
  // anything arriving while busy is dropped, and a cancel never aborts work in flight.
  assign in_busy   = (state_q == ST_BUSY);
  assign start_eff = start & ~cancel & ~in_busy;
  assign wr_eff    = md_we & ~cancel & ~in_busy;
  assign done      = in_busy && (cnt_q == CNT_W'(1));
  assign res       = md_compute(op_q, a_q, b_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      if (start_eff) begin
        op_q  <= md_op;
        a_q   <= a;
        b_q   <= b;
        cnt_q <= (md_op == OP_DIV || md_op == OP_DIVU) ? DIV_LOAD : MULT_LOAD;
      end else if (in_busy) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (done && res.wr) begin
        hi <= res.hi;
        lo <= res.lo;
      end else if (wr_eff) begin
        if (md_op == OP_MTHI) hi <= a;
        else if (md_op == OP_MTLO) lo <= a;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_eff) state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = in_busy;
    md_stall = d_md_use & (start_eff | in_busy);
  end

endmodule
